piso_tx: RTL and testbench

//   Parallel-in/serial-out transmitter: accepts a WIDTH-bit word via valid/ready, shifts it
//   out one bit per accepted beat on a serial valid/ready link. Transmit end of the serial
//   bit link whose receive end is the SIPO deserializer; built from the FLIPFLOPS library.

---
 rtl/piso_tx.sv | 124 ++++++++++++
 tb/tb_piso_tx.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter: loads a WIDTH-bit word over valid/ready and
// streams it one bit per accepted beat, chaining words back-to-back with no gap.
module piso_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             sout_first,
  output logic             sout_last,
  output logic             busy,
  output logic [7:0]       word_cnt
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               in_shift_s;
  logic               at_last_s;

  // The bit on the wire always sits at the outgoing end of the shift register.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) begin
      return {w[WIDTH-2:0], 1'b0};
    end else begin
      return {1'b0, w[WIDTH-1:1]};
    end
  endfunction

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) begin
      return w[WIDTH-1];
    end else begin
      return w[0];
    end
  endfunction

  assign in_shift_s = (state_q == ST_SHIFT);
  assign at_last_s  = in_shift_s & (idx_q == LAST_IDX);

  // Only load_ready looks at sout_ready; it lets the next word ride the last-bit beat.
  assign load_ready = ~rst & (~in_shift_s | (at_last_s & sout_ready));

  assign sout       = in_shift_s & head_bit(shreg_q);
  assign sout_valid = in_shift_s;
  assign busy       = in_shift_s;
  assign sout_first = in_shift_s & (idx_q == {IDX_W{1'b0}});
  assign sout_last  = at_last_s;
  assign word_cnt   = cnt_q;

  // Next-state computation for the transmit FSM, shift register and counters.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (load_valid) begin
          state_d = ST_SHIFT;
          shreg_d = din;
          idx_d   = {IDX_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (!sout_ready) begin
          state_d = ST_SHIFT;
        end else if (idx_q == LAST_IDX) begin
          cnt_d = cnt_q + 8'd1;
          idx_d = {IDX_W{1'b0}};
          if (load_valid) begin
            state_d = ST_SHIFT;
            shreg_d = din;
          end else begin
            state_d = ST_IDLE;
            shreg_d = {WIDTH{1'b0}};
          end
        end else begin
          idx_d   = idx_q + IDX_ONE;
          shreg_d = advance(shreg_q);
        end
      end
      default: begin
        state_d = ST_IDLE;
        shreg_d = {WIDTH{1'b0}};
        idx_d   = {IDX_W{1'b0}};
      end
    endcase
  end

  // State registers; reset drops every output to zero without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shreg_q <= {WIDTH{1'b0}};
      idx_q   <= {IDX_W{1'b0}};
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: MSB-first and LSB-first instances share stimulus; a directed
// vector table, an async-reset sequence, a 256-word stream and random traffic.
module tb_piso_tx;
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       load_valid;
  logic       sout_ready;

  logic       load_ready_m, sout_m, sout_valid_m, sout_first_m, sout_last_m, busy_m;
  logic       load_ready_l, sout_l, sout_valid_l, sout_first_l, sout_last_l, busy_l;
  logic [7:0] word_cnt_m, word_cnt_l;

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .din(din), .load_valid(load_valid), .load_ready(load_ready_m),
    .sout(sout_m), .sout_valid(sout_valid_m), .sout_ready(sout_ready),
    .sout_first(sout_first_m), .sout_last(sout_last_m), .busy(busy_m), .word_cnt(word_cnt_m)
  );

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .din(din), .load_valid(load_valid), .load_ready(load_ready_l),
    .sout(sout_l), .sout_valid(sout_valid_l), .sout_ready(sout_ready),
    .sout_first(sout_first_l), .sout_last(sout_last_l), .busy(busy_l), .word_cnt(word_cnt_l)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input logic e_valid, input logic e_sm, input logic e_sl,
                           input logic e_first, input logic e_last, input logic e_rdy,
                           input logic [7:0] e_cnt);
    chk("sout_msb",       int'(sout_m),       int'(e_sm));
    chk("sout_lsb",       int'(sout_l),       int'(e_sl));
    chk("sout_valid_msb", int'(sout_valid_m), int'(e_valid));
    chk("sout_valid_lsb", int'(sout_valid_l), int'(e_valid));
    chk("busy_msb",       int'(busy_m),       int'(e_valid));
    chk("busy_lsb",       int'(busy_l),       int'(e_valid));
    chk("first_msb",      int'(sout_first_m), int'(e_first));
    chk("first_lsb",      int'(sout_first_l), int'(e_first));
    chk("last_msb",       int'(sout_last_m),  int'(e_last));
    chk("last_lsb",       int'(sout_last_l),  int'(e_last));
    chk("load_ready_msb", int'(load_ready_m), int'(e_rdy));
    chk("load_ready_lsb", int'(load_ready_l), int'(e_rdy));
    chk("word_cnt_msb",   int'(word_cnt_m),   int'(e_cnt));
    chk("word_cnt_lsb",   int'(word_cnt_l),   int'(e_cnt));
  endtask

  // Directed vectors: inputs for one cycle and the outputs seen during that cycle.
  typedef struct {
    logic       lv;
    logic [7:0] din;
    logic       sr;
    logic       valid;
    logic       sm;
    logic       sl;
    logic       first;
    logic       last;
    logic       rdy;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic lv, input logic [7:0] d, input logic sr, input logic valid,
                     input logic sm, input logic sl, input logic first, input logic last,
                     input logic rdy, input logic [7:0] cnt);
    vec_t v;
    v.lv = lv; v.din = d; v.sr = sr; v.valid = valid; v.sm = sm; v.sl = sl;
    v.first = first; v.last = last; v.rdy = rdy; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  // Reference model: bits still owed on the wire for the word in flight, in send order.
  logic q_m[$];
  logic q_l[$];
  int   mcnt;

  task automatic model_reset(input int c);
    q_m.delete();
    q_l.delete();
    mcnt = c;
  endtask

  function automatic logic model_rdy(input logic sr);
    return (q_m.size() == 0) || (q_m.size() == 1 && sr);
  endfunction

  task automatic step(input logic lv, input logic [7:0] d, input logic sr);
    logic acc;
    load_valid = lv;
    din        = d;
    sout_ready = sr;
    #1;
    acc = lv && model_rdy(sr);
    check_all(q_m.size() > 0,
              (q_m.size() > 0) ? q_m[0] : 1'b0,
              (q_l.size() > 0) ? q_l[0] : 1'b0,
              q_m.size() == W, q_m.size() == 1, model_rdy(sr), 8'(mcnt));
    @(posedge clk);
    if (q_m.size() > 0 && sr) begin
      void'(q_m.pop_front());
      void'(q_l.pop_front());
      if (q_m.size() == 0) mcnt = (mcnt + 1) % 256;
    end
    if (acc) begin
      for (int i = 0; i < W; i++) begin
        q_m.push_back(d[W-1-i]);
        q_l.push_back(d[i]);
      end
    end
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    load_valid = 1'b0;
    din        = 8'h00;
    sout_ready = 1'b0;

    // A5 from reset, with a stray load request mid-word
    add(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    add(1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0);
    // 3C with a three-cycle stall on bit 2
    add(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    add(1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1);
    // A5 then 3C chained on the last-bit beat
    add(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2);
    add(1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd2);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd3);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd4);

    #2;
    check_all(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    #1;
    rst = 1'b0;

    foreach (tbl[i]) begin
      load_valid = tbl[i].lv;
      din        = tbl[i].din;
      sout_ready = tbl[i].sr;
      #1;
      check_all(tbl[i].valid, tbl[i].sm, tbl[i].sl, tbl[i].first, tbl[i].last,
                tbl[i].rdy, tbl[i].cnt);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset in the middle of FF, then 81 must go out cleanly
    model_reset(int'(tbl[tbl.size()-1].cnt));
    step(1'b1, 8'hFF, 1'b1);
    repeat (4) step(1'b0, 8'h00, 1'b1);
    load_valid = 1'b1;
    din        = 8'hFF;
    sout_ready = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    check_all(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    load_valid = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    chk("load_ready_after_rst_msb", int'(load_ready_m), 1);
    chk("load_ready_after_rst_lsb", int'(load_ready_l), 1);
    @(posedge clk);
    #1;
    model_reset(0);
    step(1'b1, 8'h81, 1'b1);
    repeat (9) step(1'b0, 8'h00, 1'b1);

    // 256 words back-to-back with load_valid held high throughout
    step(1'b1, 8'($urandom), 1'b1);
    for (int c = 1; c <= 2048; c++) step(c != 2048, 8'($urandom), 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("word_cnt_wrap_msb", int'(word_cnt_m), 1);
    chk("word_cnt_wrap_lsb", int'(word_cnt_l), 1);

    // Random loads and back-pressure
    repeat (3000) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
